// File: rtl/un_striping_n_if.sv
// ---------------------------------------------------------------------------
// un_striping_n_if
// Purpose : bundles the striped lane inputs, the control inputs and the
//           reassembled output stream of the un-striper into one interface.
// Signals : lane_data   NUM_LANES*DATA_WIDTH  lane i = [i*DATA_WIDTH +: DATA_WIDTH]
//           lane_valid  NUM_LANES             per-lane word valid (no backpressure)
//           resync      1                     flush + re-align request
//           out_ready   1                     downstream accepts data_out
//           data_out    DATA_WIDTH            reassembled word
//           valid_out   1                     data_out valid
//           lane_sel    SEL_W                 lane expected for the next pop
//           aligned     1                     high while streaming (RUN)
//           overflow    NUM_LANES             sticky per-lane dropped-word flag
// Modports: slave  - the un-striper itself
//           master - the upstream/downstream environment driving it
// ---------------------------------------------------------------------------
interface un_striping_n_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = 2
);
    localparam int SEL_W = $clog2(NUM_LANES);

    logic [NUM_LANES*DATA_WIDTH-1:0] lane_data;
    logic [NUM_LANES-1:0]            lane_valid;
    logic                            resync;
    logic                            out_ready;
    logic [DATA_WIDTH-1:0]           data_out;
    logic                            valid_out;
    logic [SEL_W-1:0]                lane_sel;
    logic                            aligned;
    logic [NUM_LANES-1:0]            overflow;

    modport slave (
        input  lane_data, lane_valid, resync, out_ready,
        output data_out, valid_out, lane_sel, aligned, overflow
    );

    modport master (
        output lane_data, lane_valid, resync, out_ready,
        input  data_out, valid_out, lane_sel, aligned, overflow
    );
endinterface

// File: rtl/un_striping_n.sv
// ---------------------------------------------------------------------------
// un_striping_n
// Purpose : rebuilds one ordered word stream from NUM_LANES striped lanes,
//           reading lanes 0,1,..,N-1,0,.. in strict round-robin order. Each
//           lane owns a small elastic FIFO so lanes may arrive skewed; the
//           stream aligns on the first lane 0 word after reset/resync.
// Ports   : clk    - sole clock, all logic on posedge
//           reset  - synchronous, active-high
//           bus    - un_striping_n_if.slave (lane inputs, resync, out_ready,
//                    data_out/valid_out, lane_sel, aligned, overflow)
// ---------------------------------------------------------------------------
module un_striping_n #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    un_striping_n_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_LANES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  mem_q   [NUM_LANES][FIFO_DEPTH];
    logic [PTR_W-1:0]       wrPtr_q [NUM_LANES];
    logic [PTR_W-1:0]       rdPtr_q [NUM_LANES];
    logic [CNT_W-1:0]       count_q [NUM_LANES];
    logic [CNT_W-1:0]       count_d [NUM_LANES];
    logic [NUM_LANES-1:0]   overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]  dataOut_q, dataOut_d;
    logic                   validOut_q, validOut_d;
    logic [SEL_W-1:0]       laneSel_q, laneSel_d;

    logic                   flush;
    logic                   outFree;
    logic                   popEn;
    logic [DATA_WIDTH-1:0]  headWord;
    logic [NUM_LANES-1:0]   fifoEmpty, fifoFull;
    logic [NUM_LANES-1:0]   wrReq, wrOk, ovfSet, popLane;

    // Lane FIFO bookkeeping and the pop decision. Empty/full come straight
    // from the registered counts, so a word written at one edge can only be
    // popped at the next one. A full lane still accepts a write when the
    // same lane is popped in that cycle; otherwise the word is dropped and
    // the lane's sticky overflow flag is raised. In IDLE, writes only happen
    // on a cycle where lane 0 is valid, which is what aligns the stream.
    always_comb begin
        flush      = reset || bus.resync;
        outFree    = !validOut_q || bus.out_ready;
        fifoEmpty  = '0;
        fifoFull   = '0;
        wrReq      = '0;
        wrOk       = '0;
        ovfSet     = '0;
        popLane    = '0;
        overflow_d = overflow_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            fifoEmpty[i] = (count_q[i] == '0);
            fifoFull[i]  = (count_q[i] == CNT_W'(FIFO_DEPTH));
        end
        popEn    = !flush && (state_q == RUN) && !fifoEmpty[laneSel_q] && outFree;
        headWord = mem_q[laneSel_q][rdPtr_q[laneSel_q]];
        for (int i = 0; i < NUM_LANES; i++) begin
            popLane[i] = popEn && (laneSel_q == SEL_W'(i));
            wrReq[i]   = !flush && bus.lane_valid[i]
                         && ((state_q == RUN) || bus.lane_valid[0]);
            wrOk[i]    = wrReq[i] && (!fifoFull[i] || popLane[i]);
            ovfSet[i]  = wrReq[i] && fifoFull[i] && !popLane[i];
            count_d[i] = count_q[i] + CNT_W'(wrOk[i]) - CNT_W'(popLane[i]);
        end
        overflow_d = overflow_q | ovfSet;
    end

    // Next-state and output register logic. A pop loads the output register
    // and advances lane_sel; without a pop, an accepted word simply retires
    // (valid drops) while a held word keeps data, valid and lane_sel frozen.
    always_comb begin
        state_d    = state_q;
        dataOut_d  = dataOut_q;
        validOut_d = validOut_q;
        laneSel_d  = laneSel_q;
        if ((state_q == IDLE) && bus.lane_valid[0]) begin
            state_d = RUN;
        end
        if (popEn) begin
            dataOut_d  = headWord;
            validOut_d = 1'b1;
            laneSel_d  = (laneSel_q == SEL_W'(NUM_LANES - 1)) ? '0
                                                               : laneSel_q + SEL_W'(1);
        end else if (bus.out_ready) begin
            validOut_d = 1'b0;
        end
    end

    // State, pointers, counts and outputs. reset and resync both perform the
    // full flush; lane inputs seen in that cycle are ignored.
    always_ff @(posedge clk) begin
        if (reset || bus.resync) begin
            state_q    <= IDLE;
            overflow_q <= '0;
            dataOut_q  <= '0;
            validOut_q <= 1'b0;
            laneSel_q  <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                wrPtr_q[i] <= '0;
                rdPtr_q[i] <= '0;
                count_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            dataOut_q  <= dataOut_d;
            validOut_q <= validOut_d;
            laneSel_q  <= laneSel_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                wrPtr_q[i] <= wrPtr_q[i] + PTR_W'(wrOk[i]);
                rdPtr_q[i] <= rdPtr_q[i] + PTR_W'(popLane[i]);
                count_q[i] <= count_d[i];
            end
        end
    end

    // FIFO storage needs no reset: the pointers and counts define what is
    // live, so stale contents are never read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wrOk[i]) begin
                mem_q[i][wrPtr_q[i]] <= bus.lane_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.data_out  = dataOut_q;
    assign bus.valid_out = validOut_q;
    assign bus.lane_sel  = laneSel_q;
    assign bus.aligned   = (state_q == RUN);
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_un_striping_n.sv
// ---------------------------------------------------------------------------
// tb_un_striping_n
// Purpose : directed check of the un-striper with a 2-lane instance (order,
//           alignment, backpressure, overflow, resync) and a 4-lane instance
//           (skewed lane 3). Inputs change and outputs are sampled 1 ns after
//           each rising edge.
// ---------------------------------------------------------------------------
module tb_un_striping_n;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    un_striping_n_if #(.DATA_WIDTH(DW), .NUM_LANES(2)) bus2 ();
    un_striping_n_if #(.DATA_WIDTH(DW), .NUM_LANES(4)) bus4 ();

    un_striping_n #(.DATA_WIDTH(DW), .NUM_LANES(2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    un_striping_n #(.DATA_WIDTH(DW), .NUM_LANES(4), .FIFO_DEPTH(DEPTH)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts the vector and reports any miscompare.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of lane traffic on the 2-lane instance.
    task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] w0,
                                 input logic [31:0] w1);
        bus2.lane_valid = valid;
        bus2.lane_data  = {w1, w0};
        tick();
    endtask

    logic [31:0] expSeq4 [5] = '{32'h30, 32'h21, 32'h31, 32'h22, 32'h32};
    logic [31:0] expSeq5 [8] = '{32'h41, 32'h51, 32'h42, 32'h52,
                                 32'h43, 32'h53, 32'h44, 32'h54};

    initial begin
        $display("[TB] start");
        reset           = 1'b1;
        bus2.lane_data  = '0;
        bus2.lane_valid = '0;
        bus2.resync     = 1'b0;
        bus2.out_ready  = 1'b0;
        bus4.lane_data  = '0;
        bus4.lane_valid = '0;
        bus4.resync     = 1'b0;
        bus4.out_ready  = 1'b0;
        tick();
        tick();
        checkOutput("rst valid_out", 32'(bus2.valid_out), 32'h0);
        checkOutput("rst aligned",   32'(bus2.aligned),   32'h0);
        checkOutput("rst lane_sel",  32'(bus2.lane_sel),  32'h0);
        checkOutput("rst overflow",  32'(bus2.overflow),  32'h0);
        checkOutput("rst data_out",  bus2.data_out,       32'h0);
        checkOutput("rst n4 valid",  32'(bus4.valid_out), 32'h0);
        reset          = 1'b0;
        bus2.out_ready = 1'b1;
        bus4.out_ready = 1'b1;
        tick();

        // Basic 2-lane reassembly: A0,B0 then a gap then A1,B1.
        $display("[TB] basic order");
        applyStimulus(2'b11, 32'hA0, 32'hB0);
        checkOutput("s1 no bypass", 32'(bus2.valid_out), 32'h0);
        checkOutput("s1 aligned",   32'(bus2.aligned),   32'h1);
        applyStimulus(2'b00, 32'h0, 32'h0);
        checkOutput("s1 first valid", 32'(bus2.valid_out), 32'h1);
        checkOutput("s1 A0",          bus2.data_out,       32'hA0);
        checkOutput("s1 sel after A0", 32'(bus2.lane_sel), 32'h1);
        applyStimulus(2'b11, 32'hA1, 32'hB1);
        checkOutput("s1 B0", bus2.data_out, 32'hB0);
        applyStimulus(2'b00, 32'h0, 32'h0);
        checkOutput("s1 A1", bus2.data_out, 32'hA1);
        applyStimulus(2'b00, 32'h0, 32'h0);
        checkOutput("s1 B1",     bus2.data_out,      32'hB1);
        checkOutput("s1 sel B1", 32'(bus2.lane_sel), 32'h0);
        applyStimulus(2'b00, 32'h0, 32'h0);
        checkOutput("s1 drained", 32'(bus2.valid_out), 32'h0);

        // 4-lane skew: lanes 0-2 together, lane 3 four edges later, which
        // leaves lane_sel parked on 3 with nothing to pop for one cycle.
        $display("[TB] 4-lane skew");
        bus4.lane_valid = 4'b0111;
        bus4.lane_data  = {32'h0, 32'h12, 32'h11, 32'h10};
        tick();
        bus4.lane_valid = 4'b0000;
        tick();
        checkOutput("s3 w0", bus4.data_out, 32'h10);
        tick();
        checkOutput("s3 w1", bus4.data_out, 32'h11);
        tick();
        checkOutput("s3 w2",     bus4.data_out,      32'h12);
        checkOutput("s3 sel w2", 32'(bus4.lane_sel), 32'h3);
        bus4.lane_valid = 4'b1000;
        bus4.lane_data  = {32'h13, 32'h0, 32'h0, 32'h0};
        tick();
        checkOutput("s3 wait valid", 32'(bus4.valid_out), 32'h0);
        checkOutput("s3 wait sel",   32'(bus4.lane_sel),  32'h3);
        bus4.lane_valid = 4'b0000;
        tick();
        checkOutput("s3 w3",       bus4.data_out,       32'h13);
        checkOutput("s3 w3 valid", 32'(bus4.valid_out), 32'h1);
        checkOutput("s3 sel wrap", 32'(bus4.lane_sel),  32'h0);

        // IDLE alignment: lane 1 words before any lane 0 word are dropped.
        $display("[TB] idle align");
        reset = 1'b1;
        applyStimulus(2'b00, 32'h0, 32'h0);
        reset = 1'b0;
        applyStimulus(2'b10, 32'h0, 32'hE1);
        applyStimulus(2'b10, 32'h0, 32'hE2);
        applyStimulus(2'b10, 32'h0, 32'hE3);
        checkOutput("s2 still idle", 32'(bus2.aligned),   32'h0);
        checkOutput("s2 no output",  32'(bus2.valid_out), 32'h0);
        applyStimulus(2'b11, 32'hC0, 32'hD0);
        checkOutput("s2 aligned", 32'(bus2.aligned), 32'h1);
        applyStimulus(2'b00, 32'h0, 32'h0);
        checkOutput("s2 first lane0", bus2.data_out, 32'hC0);
        applyStimulus(2'b00, 32'h0, 32'h0);
        checkOutput("s2 lane1 word", bus2.data_out, 32'hD0);
        applyStimulus(2'b00, 32'h0, 32'h0);
        checkOutput("s2 overflow", 32'(bus2.overflow),  32'h0);
        checkOutput("s2 drained",  32'(bus2.valid_out), 32'h0);

        // Backpressure: out_ready low for five edges with a word held.
        $display("[TB] backpressure");
        applyStimulus(2'b11, 32'h20, 32'h30);
        applyStimulus(2'b11, 32'h21, 32'h31);
        checkOutput("s4 first", bus2.data_out, 32'h20);
        bus2.out_ready = 1'b0;
        applyStimulus(2'b11, 32'h22, 32'h32);
        checkOutput("s4 hold valid", 32'(bus2.valid_out), 32'h1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b00, 32'h0, 32'h0);
            checkOutput("s4 hold data", bus2.data_out,      32'h20);
            checkOutput("s4 hold sel",  32'(bus2.lane_sel), 32'h1);
        end
        bus2.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(2'b00, 32'h0, 32'h0);
            checkOutput("s4 release order", bus2.data_out, expSeq4[k]);
        end
        applyStimulus(2'b00, 32'h0, 32'h0);
        checkOutput("s4 drained", 32'(bus2.valid_out), 32'h0);

        // Overflow: with out_ready low the output register absorbs 0x40, so
        // lane 0 fills on 0x41..0x44 and 0x45 is the dropped word. Lane 1 is
        // then written while full in the same cycle it is popped.
        $display("[TB] overflow");
        bus2.out_ready = 1'b0;
        applyStimulus(2'b11, 32'h40, 32'h50);
        applyStimulus(2'b11, 32'h41, 32'h51);
        applyStimulus(2'b11, 32'h42, 32'h52);
        applyStimulus(2'b11, 32'h43, 32'h53);
        applyStimulus(2'b01, 32'h44, 32'h0);
        checkOutput("s5 full no flag", 32'(bus2.overflow), 32'h0);
        applyStimulus(2'b01, 32'h45, 32'h0);
        checkOutput("s5 overflow set", 32'(bus2.overflow), 32'h1);
        checkOutput("s5 held word",    bus2.data_out,      32'h40);
        bus2.out_ready = 1'b1;
        applyStimulus(2'b10, 32'h0, 32'h54);
        checkOutput("s5 full+pop data",  bus2.data_out,      32'h50);
        checkOutput("s5 full+pop flags", 32'(bus2.overflow), 32'h1);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(2'b00, 32'h0, 32'h0);
            checkOutput("s5 drain order", bus2.data_out, expSeq5[k]);
        end
        applyStimulus(2'b00, 32'h0, 32'h0);
        checkOutput("s5 dropped absent", 32'(bus2.valid_out), 32'h0);

        // Resync mid-stream with a held word and queued words.
        $display("[TB] resync");
        bus2.out_ready = 1'b0;
        applyStimulus(2'b11, 32'h60, 32'h70);
        applyStimulus(2'b11, 32'h61, 32'h71);
        checkOutput("s6 held", bus2.data_out, 32'h60);
        bus2.resync = 1'b1;
        applyStimulus(2'b11, 32'h62, 32'h72);
        checkOutput("s6 valid cleared",    32'(bus2.valid_out), 32'h0);
        checkOutput("s6 aligned cleared",  32'(bus2.aligned),   32'h0);
        checkOutput("s6 overflow cleared", 32'(bus2.overflow),  32'h0);
        checkOutput("s6 sel cleared",      32'(bus2.lane_sel),  32'h0);
        checkOutput("s6 data cleared",     bus2.data_out,       32'h0);
        bus2.resync    = 1'b0;
        bus2.out_ready = 1'b1;
        applyStimulus(2'b11, 32'h80, 32'h90);
        applyStimulus(2'b00, 32'h0, 32'h0);
        checkOutput("s6 restart lane0", bus2.data_out, 32'h80);
        applyStimulus(2'b00, 32'h0, 32'h0);
        checkOutput("s6 restart lane1", bus2.data_out, 32'h90);
        applyStimulus(2'b00, 32'h0, 32'h0);
        checkOutput("s6 flushed queue", 32'(bus2.valid_out), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
